fifo_write_ctrl: RTL and testbench
==================================

FIFO_WRITE_CTRL -- requirements
Module: fifo_write_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, meaning buffer address width; depth = 2^ADDR_WIDTH; legal range 2..16.
REQ-002 The block SHALL have parameter AF_MARGIN, default 2, meaning almost_full asserts when free entries <= AF_MARGIN; legal range 1..depth-1.
REQ-003 Port write_clock, input, 1 bit: the single clock, write domain; all state changes on its rising edge.
REQ-004 Port write_reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 Port write_enable, input, 1 bit: producer write request for this cycle.
REQ-006 Port read_ptr_gray, input, ADDR_WIDTH+1 bits: read pointer in Gray code, asynchronous to write_clock.
REQ-007 Port write_addr, output, ADDR_WIDTH bits: buffer write address.
REQ-008 Port write_ptr_gray, output, ADDR_WIDTH+1 bits: registered Gray write pointer, for export to the read domain.
REQ-009 Port write_full, output, 1 bit: buffer full; also routed to the buffer's write_full input.
REQ-010 Port write_almost_full, output, 1 bit: free entries <= AF_MARGIN.
REQ-011 Port write_level, output, ADDR_WIDTH+1 bits: occupancy as seen from the write domain, 0..depth.

Function
REQ-012 read_ptr_gray SHALL pass through a 2-flop synchronizer (rq1 -> rq2) clocked by write_clock; only rq2 is used downstream.
REQ-013 The write pointer SHALL be an (ADDR_WIDTH+1)-bit binary counter wbin; write_addr = wbin[ADDR_WIDTH-1:0], taken straight from the register with no combinational path from write_enable.
REQ-014 Accept condition: write_inc = write_enable AND NOT write_full; wbin_next = wbin + write_inc, modulo 2^(ADDR_WIDTH+1).
REQ-015 gray_next = wbin_next XOR (wbin_next >> 1); write_ptr_gray SHALL be registered from gray_next and change by exactly one bit per accepted write.
REQ-016 write_full SHALL be registered from (gray_next == rq2 with its two MSBs inverted) and SHALL be updated on every edge, whether or not a write is accepted.
REQ-017 A write attempted while write_full = 1 SHALL be ignored: wbin, write_ptr_gray and write_addr hold.
REQ-018 rbin_sync SHALL be gray-to-binary of rq2; write_level SHALL be registered from (wbin_next - rbin_sync) mod 2^(ADDR_WIDTH+1).
REQ-019 write_almost_full SHALL be registered from (depth - level_next) <= AF_MARGIN; it is asserted whenever write_full is asserted.
REQ-020 Wrap-around: at wbin = 2^(ADDR_WIDTH+1)-1, an accepted write SHALL take wbin to 0 with no glitch or stall.
REQ-021 Latency: an accepted write SHALL be visible on write_addr, write_ptr_gray and write_level at the next edge; a read-pointer change SHALL affect full, almost_full and level at the 3rd write_clock edge after it is stable at the input.
REQ-022 Flags are pessimistic: the block SHALL never deassert write_full while the buffer is actually full; staleness SHALL only delay deassertion.

Reset
REQ-023 While write_reset_n = 0, the block SHALL asynchronously clear wbin, write_ptr_gray, rq1, rq2, write_level, write_full and write_almost_full to 0.
REQ-024 Reset asserted mid-operation SHALL discard in-flight state; the first accepted write after release SHALL use write_addr = 0.
REQ-025 Reset release SHALL take effect on the first write_clock edge after write_reset_n rises.

Structure
REQ-026 The shared package SHALL hold the gray-to-binary and binary-to-gray functions and the default ADDR_WIDTH constant; the read-side controller also uses them.
REQ-027 The synchronizer SHALL be a separate sub-module named ptr_sync_2ff (parameter WIDTH, async active-low reset), reused by the read side.

Verification
REQ-028 Reset, ADDR_WIDTH=4: write_full=0, write_almost_full=0, write_addr=0, write_ptr_gray=0, write_level=0.
REQ-029 read_ptr_gray held at 0, 16 consecutive writes: write_almost_full rises after the 14th write, write_full rises after the 16th; write_addr=0, write_ptr_gray=5'b11000, write_level=16.
REQ-030 While full, write_enable held for 5 cycles: wbin, write_ptr_gray and write_level unchanged.
REQ-031 While full, read_ptr_gray set to 5'b00001: write_full clears exactly at the 3rd edge; write_level=15.
REQ-032 70 writes interleaved with a Gray read pointer tracking 2 entries behind: write_ptr_gray has Hamming distance 1 per accept, wrap passes 31->0, no spurious full.
REQ-033 write_reset_n pulsed low mid-burst between edges: all outputs go to 0 immediately; the next write lands at write_addr=0.

Source files
------------

// File: rtl/fifo_write_ctrl_pkg.sv
// Shared pointer helpers for the async FIFO write and read controllers.
// Pointers are handled at a fixed maximum width; callers zero-extend in and truncate out.
package fifo_write_ctrl_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int MAX_PTR_WIDTH      = 17;

  typedef logic [MAX_PTR_WIDTH-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin[MAX_PTR_WIDTH-1] = gray[MAX_PTR_WIDTH-1];
    for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module ptr_sync_2ff #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side controller of an async FIFO: write pointer, Gray export and
// pessimistic full / almost-full / level flags against the synchronized read pointer.
module fifo_write_ctrl
  import fifo_write_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  write_clock,
  input  logic                  write_reset_n,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH:0]   read_ptr_gray,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH:0]   write_ptr_gray,
  output logic                  write_full,
  output logic                  write_almost_full,
  output logic [ADDR_WIDTH:0]   write_level
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [PTR_W-1:0] rq2;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] gray_next;
  logic [PTR_W-1:0] rbin_sync;
  logic [PTR_W-1:0] level_next;
  logic [PTR_W-1:0] full_pattern;
  logic [PTR_W:0]   free_next;
  logic             write_inc;
  logic             full_next;
  logic             almost_full_next;

  ptr_sync_2ff #(
    .WIDTH (PTR_W)
  ) u_read_ptr_sync (
    .clk   (write_clock),
    .rst_n (write_reset_n),
    .d     (read_ptr_gray),
    .q     (rq2)
  );

  // Full when the write pointer is exactly one lap ahead: Gray equality with the two MSBs flipped.
  always_comb begin
    write_inc        = write_enable & ~write_full;
    wbin_next        = wbin + PTR_W'(write_inc);
    gray_next        = PTR_W'(bin2gray(ptr_t'(wbin_next)));
    rbin_sync        = PTR_W'(gray2bin(ptr_t'(rq2)));
    level_next       = wbin_next - rbin_sync;
    full_pattern     = {~rq2[PTR_W-1 -: 2], rq2[PTR_W-3:0]};
    full_next        = (gray_next == full_pattern);
    free_next        = (PTR_W+1)'(DEPTH) - {1'b0, level_next};
    almost_full_next = (free_next <= (PTR_W+1)'(AF_MARGIN));
  end

  always_ff @(posedge write_clock or negedge write_reset_n) begin
    if (!write_reset_n) begin
      wbin              <= '0;
      write_ptr_gray    <= '0;
      write_full        <= 1'b0;
      write_almost_full <= 1'b0;
      write_level       <= '0;
    end else begin
      wbin              <= wbin_next;
      write_ptr_gray    <= gray_next;
      write_full        <= full_next;
      write_almost_full <= almost_full_next;
      write_level       <= level_next;
    end
  end

  assign write_addr = wbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Bench for fifo_write_ctrl: directed vector table, full-release sequence,
// randomized run against an occupancy-counting model, and a mid-burst reset.
module tb_fifo_write_ctrl;

  localparam int ADDR_WIDTH = 4;
  localparam int AF_MARGIN  = 2;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  logic       write_clock;
  logic       write_reset_n;
  logic       write_enable;
  logic [4:0] read_ptr_gray;
  logic [3:0] write_addr;
  logic [4:0] write_ptr_gray;
  logic       write_full;
  logic       write_almost_full;
  logic [4:0] write_level;

  fifo_write_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_MARGIN  (AF_MARGIN)
  ) dut (
    .write_clock       (write_clock),
    .write_reset_n     (write_reset_n),
    .write_enable      (write_enable),
    .read_ptr_gray     (read_ptr_gray),
    .write_addr        (write_addr),
    .write_ptr_gray    (write_ptr_gray),
    .write_full        (write_full),
    .write_almost_full (write_almost_full),
    .write_level       (write_level)
  );

  initial write_clock = 1'b0;
  always #5 write_clock = ~write_clock;

  typedef struct {
    logic we;
    int   rd;
    logic full;
    logic af;
    int   addr;
    int   gray;
    int   level;
  } vec_t;

  vec_t vecs[21];
  int   n_vectors;
  int   n_miscompares;

  // Model state: total writes accepted and total reads as plain counts.
  int   wr_count;
  int   rd_count;
  int   rd_hist[$];
  int   m_level;
  bit   model_full;
  bit   model_af;
  bit   last_acc;
  int   last_hamming;
  int   wraps;

  function automatic logic [4:0] to_gray(input int n);
    logic [4:0] b;
    b = 5'(n % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic modelReset();
    wr_count   = 0;
    rd_count   = 0;
    rd_hist    = {0, 0};
    m_level    = 0;
    model_full = 1'b0;
    model_af   = 1'b0;
  endtask

  task automatic applyStimulus(input logic we, input int rd);
    logic [4:0] gray_before;
    int         used;
    write_enable  = we;
    read_ptr_gray = to_gray(rd);
    gray_before   = write_ptr_gray;
    @(posedge write_clock);
    last_acc = we && !model_full;
    if (last_acc) begin
      if (wr_count % 32 == 31) wraps++;
      wr_count++;
    end
    // The read count seen by the flags lags the input by two edges.
    used = rd_hist.pop_front();
    rd_hist.push_back(rd);
    m_level    = wr_count - used;
    model_full = (m_level == DEPTH);
    model_af   = ((DEPTH - m_level) <= AF_MARGIN);
    #1;
    last_hamming = $countones(gray_before ^ write_ptr_gray);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int full, input int af,
                          input int addr, input int gray, input int level);
    checkOutput({tag, ".full"},  int'(write_full),        full);
    checkOutput({tag, ".af"},    int'(write_almost_full), af);
    checkOutput({tag, ".addr"},  int'(write_addr),        addr);
    checkOutput({tag, ".gray"},  int'(write_ptr_gray),    gray);
    checkOutput({tag, ".level"}, int'(write_level),       level);
  endtask

  task automatic checkModel(input string tag);
    checkAll(tag, int'(model_full), int'(model_af), wr_count % DEPTH,
             int'(to_gray(wr_count)), m_level);
  endtask

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    wraps         = 0;
    modelReset();

    // Fill phase: 16 writes against an idle reader, then 5 blocked attempts while full.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{we: 1'b1, rd: 0, full: (i == 15), af: ((i + 1) >= 14),
                  addr: (i + 1) % 16, gray: int'(to_gray(i + 1)), level: i + 1};
    end
    for (int i = 16; i < 21; i++) begin
      vecs[i] = '{we: 1'b1, rd: 0, full: 1'b1, af: 1'b1,
                  addr: 0, gray: 5'b11000, level: 16};
    end

    write_reset_n = 1'b0;
    write_enable  = 1'b0;
    read_ptr_gray = '0;
    #12;
    checkAll("reset", 0, 0, 0, 0, 0);
    write_reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].we, vecs[i].rd);
      checkAll($sformatf("vec%0d", i), int'(vecs[i].full), int'(vecs[i].af),
               vecs[i].addr, vecs[i].gray, vecs[i].level);
    end

    // One read appears while full: flags follow on the third edge.
    rd_count = 1;
    applyStimulus(1'b0, rd_count);
    checkAll("release_e1", 1, 1, 0, 5'b11000, 16);
    applyStimulus(1'b0, rd_count);
    checkAll("release_e2", 1, 1, 0, 5'b11000, 16);
    applyStimulus(1'b0, rd_count);
    checkAll("release_e3", 0, 1, 0, 5'b11000, 15);

    // Random traffic with the reader trailing two entries behind.
    for (int c = 0; c < 200; c++) begin
      logic we;
      we = ($urandom_range(0, 3) != 0);
      if ((rd_count < wr_count - 2) && ($urandom_range(0, 4) != 0)) rd_count++;
      applyStimulus(we, rd_count);
      checkModel($sformatf("rand%0d", c));
      checkOutput($sformatf("rand%0d.hamming", c), last_hamming, last_acc ? 1 : 0);
    end
    $display("[TB] random phase done: %0d writes, %0d pointer wraps", wr_count, wraps);

    // Reset pulse between edges in the middle of a burst.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, rd_count);
      checkModel($sformatf("burst%0d", c));
    end
    #3;
    write_reset_n = 1'b0;
    #1;
    checkAll("midreset", 0, 0, 0, 0, 0);
    modelReset();
    read_ptr_gray = '0;
    #1;
    write_reset_n = 1'b1;
    checkOutput("post_reset_addr", int'(write_addr), 0);
    applyStimulus(1'b1, 0);
    checkAll("post_reset_write", 0, 0, 1, 1, 1);
    checkModel("post_reset_model");

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
